// File: rtl/pwm_rx.sv
// pwm_rx: recovers PWM frames from a single-bit line and emits one W-bit duty sample per frame.
// Optional define PWM_RX_GLITCH_FILTER_EN rejects single-cycle pulses on the synchronized line.
module pwm_rx #(
   parameter int PERIOD  = 256,
   parameter int W       = 8,
   parameter int TOL     = 4,
   parameter int TIMEOUT = 512
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pwm_in,
   output logic [W-1:0] sample,
   output logic         sample_valid,
   output logic         period_err,
   output logic         locked
);
   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] HIGH_MAX = CW'((2 ** W) - 1);
   localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT);
   localparam logic [CW-1:0] PER_VAL  = CW'(PERIOD);
   localparam logic [CW-1:0] TOL_VAL  = CW'(TOL);

   typedef enum logic {IDLE, TRACK} state_t;
   state_t state, state_next;

   logic          sync1, sync2, lvl_q, lvl;
   logic          rise, timeout, restart, out_of_tol;
   logic [CW-1:0] period_cnt, high_cnt, deviation;
   logic [W-1:0]  sample_next;
   logic          valid_next, err_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         lvl_q <= 1'b0;
      end else begin
         sync1 <= pwm_in;
         sync2 <= sync1;
         lvl_q <= lvl;
      end
   end

`ifdef PWM_RX_GLITCH_FILTER_EN
   logic sync3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync3 <= 1'b0;
      else        sync3 <= sync2;
   end

   // The level only moves once two consecutive synchronized samples agree.
   assign lvl = (sync2 == sync3) ? sync2 : lvl_q;
`else
   assign lvl = sync2;
`endif

   assign rise    = lvl & ~lvl_q;
   assign timeout = (period_cnt == TO_VAL);

   always_comb begin
      deviation  = (period_cnt >= PER_VAL) ? (period_cnt - PER_VAL) : (PER_VAL - period_cnt);
      out_of_tol = (deviation > TOL_VAL);
   end

   // A rise outranks a coincident timeout; the first rise from IDLE only sets the frame reference.
   always_comb begin
      state_next  = state;
      sample_next = sample;
      valid_next  = 1'b0;
      err_next    = 1'b0;
      restart     = 1'b0;
      if (rise) begin
         restart    = 1'b1;
         state_next = TRACK;
         if (state == TRACK) begin
            sample_next = high_cnt[W-1:0];
            valid_next  = 1'b1;
            err_next    = out_of_tol;
         end
      end else if (timeout) begin
         restart     = 1'b1;
         state_next  = IDLE;
         sample_next = {W{lvl}};
         valid_next  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         sample       <= '0;
         sample_valid <= 1'b0;
         period_err   <= 1'b0;
      end else begin
         state        <= state_next;
         sample       <= sample_next;
         sample_valid <= valid_next;
         period_err   <= err_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt <= '0;
         high_cnt   <= '0;
      end else if (restart) begin
         period_cnt <= CW'(1);
         high_cnt   <= CW'(1);
      end else begin
         if (period_cnt != CNT_MAX) period_cnt <= period_cnt + CW'(1);
         if (lvl && (high_cnt != HIGH_MAX)) high_cnt <= high_cnt + CW'(1);
      end
   end

   assign locked = (state == TRACK);

endmodule

// File: tb/tb_pwm_rx.sv
// tb_pwm_rx: drives directed and random PWM frames into pwm_rx and checks every cycle
// against a frame-level model, plus literal expectations for the key scenarios.
module tb_pwm_rx;
   localparam int PERIOD  = 256;
   localparam int W       = 8;
   localparam int TOL     = 4;
   localparam int TIMEOUT = 512;
`ifdef PWM_RX_GLITCH_FILTER_EN
   localparam int LAT           = 4;
   localparam int D_LO          = 2;
   localparam int D_HI          = 254;
   localparam int GLITCH_SAMPLE = 64;
   localparam int GLITCH_ERR    = 0;
`else
   localparam int LAT           = 3;
   localparam int D_LO          = 1;
   localparam int D_HI          = 255;
   localparam int GLITCH_SAMPLE = 1;
   localparam int GLITCH_ERR    = 1;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         pwm_in;
   logic [W-1:0] sample;
   logic         sample_valid;
   logic         period_err;
   logic         locked;

   int vectors     = 0;
   int miscompares = 0;

   pwm_rx #(.PERIOD(PERIOD), .W(W), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pwm_in       (pwm_in),
      .sample       (sample),
      .sample_valid (sample_valid),
      .period_err   (period_err),
      .locked       (locked)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Frame-level model: the decoder sees the line two cycles late, measures rise-to-rise
   // spacing and the number of high cycles in between, and times out after TIMEOUT cycles.
   int  n = 0;
   int  c0 = 0;
   int  ref_c = 0;
   bit  in_rst = 1'b1;
   bit  p_hist  [0:65535];
   bit  lv_hist [0:65535];
   bit  raw_prev = 1'b0;
   bit  m_trk = 1'b0;
   int  m_sample = 0;
   bit  m_valid = 1'b0;
   bit  m_err = 1'b0;

   always @(negedge clk) begin
      bit raw;
      bit lv;
      bit rise;
      int high;
      int per;
      if (!rst_n) begin
         in_rst   = 1'b1;
         m_trk    = 1'b0;
         m_sample = 0;
         m_valid  = 1'b0;
         m_err    = 1'b0;
         checkOutput("rst_sample", int'(sample), 0);
         checkOutput("rst_valid", int'(sample_valid), 0);
         checkOutput("rst_err", int'(period_err), 0);
         checkOutput("rst_locked", int'(locked), 0);
      end else begin
         if (in_rst) begin
            in_rst   = 1'b0;
            c0       = n;
            ref_c    = n;
            raw_prev = 1'b0;
         end
         checkOutput("mdl_sample", int'(sample), m_sample);
         checkOutput("mdl_valid", int'(sample_valid), int'(m_valid));
         checkOutput("mdl_err", int'(period_err), int'(m_err));
         checkOutput("mdl_locked", int'(locked), int'(m_trk));
         raw = (n >= c0 + 2) ? p_hist[n-2] : 1'b0;
`ifdef PWM_RX_GLITCH_FILTER_EN
         lv = (n == c0) ? 1'b0 : ((raw == raw_prev) ? raw : lv_hist[n-1]);
`else
         lv = raw;
`endif
         raw_prev   = raw;
         lv_hist[n] = lv;
         rise       = lv && (n > c0) && !lv_hist[n-1];
         per        = n - ref_c;
         m_valid    = 1'b0;
         m_err      = 1'b0;
         if (rise) begin
            if (m_trk) begin
               high = 0;
               for (int k = ref_c; k < n; k++) high += int'(lv_hist[k]);
               if (high > 255) high = 255;
               m_sample = high;
               m_valid  = 1'b1;
               m_err    = (per > PERIOD + TOL) || (per < PERIOD - TOL);
            end
            m_trk = 1'b1;
            ref_c = n;
         end else if (per == TIMEOUT) begin
            m_sample = lv ? 255 : 0;
            m_valid  = 1'b1;
            m_trk    = 1'b0;
            ref_c    = n;
         end
      end
      if (n < 65535) begin
         p_hist[n] = pwm_in;
         n++;
      end
   end

   // mode 1: the rise of this frame must strobe exp_s/exp_e; mode 2: it must not strobe.
   task automatic applyStimulus(input int len, input int d, input int mode, input int exp_s,
                                input int exp_e, input bit chk_to, input int exp_to,
                                input int glitch_at, input int rst_at);
      for (int i = 0; i < len; i++) begin
         @(posedge clk);
         #1;
         pwm_in = (i < d) || (i == glitch_at);
         rst_n  = (i != rst_at);
         if (i == rst_at) begin
            #1;
            checkOutput("reset_mid_sample", int'(sample), 0);
            checkOutput("reset_mid_valid", int'(sample_valid), 0);
            checkOutput("reset_mid_err", int'(period_err), 0);
            checkOutput("reset_mid_locked", int'(locked), 0);
         end
         if (mode == 1 && i == LAT - 1) checkOutput("strobe_early", int'(sample_valid), 0);
         if (mode == 1 && i == LAT) begin
            checkOutput("strobe_valid", int'(sample_valid), 1);
            checkOutput("strobe_sample", int'(sample), exp_s);
            checkOutput("strobe_err", int'(period_err), exp_e);
            checkOutput("strobe_locked", int'(locked), 1);
         end
         if (mode == 2 && i == LAT) begin
            checkOutput("first_rise_valid", int'(sample_valid), 0);
            checkOutput("first_rise_locked", int'(locked), 1);
         end
         if (chk_to && i == LAT + TIMEOUT - 1) checkOutput("pre_timeout_locked", int'(locked), 1);
         if (chk_to && i == LAT + TIMEOUT) begin
            checkOutput("timeout_valid", int'(sample_valid), 1);
            checkOutput("timeout_sample", int'(sample), exp_to);
            checkOutput("timeout_err", int'(period_err), 0);
            checkOutput("timeout_locked", int'(locked), 0);
         end
      end
   endtask

   task automatic runFrame(input int len, input int d, input int mode, input int exp_s, input int exp_e);
      applyStimulus(len, d, mode, exp_s, exp_e, 1'b0, 0, -1, -1);
   endtask

   initial begin
      rst_n  = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_sample", int'(sample), 0);
      checkOutput("reset_valid", int'(sample_valid), 0);
      checkOutput("reset_locked", int'(locked), 0);
      rst_n = 1'b1;

      runFrame(256, 64, 2, 0, 0);
      repeat (3) runFrame(256, 64, 1, 64, 0);

      runFrame(256, D_LO, 1, 64, 0);
      runFrame(256, 128, 1, D_LO, 0);
      runFrame(256, D_HI, 1, 128, 0);
      runFrame(256, 64, 1, D_HI, 0);

      runFrame(262, 100, 1, 64, 0);
      runFrame(259, 100, 1, 100, 1);
      runFrame(256, 64, 1, 100, 0);

      applyStimulus(256, 64, 1, 64, 0, 1'b0, 0, 150, -1);
      runFrame(256, 64, 1, GLITCH_SAMPLE, GLITCH_ERR);

      applyStimulus(600, 64, 1, 64, 0, 1'b1, 0, -1, -1);
      runFrame(256, 64, 2, 0, 0);
      runFrame(256, 64, 1, 64, 0);

      applyStimulus(600, 600, 1, 64, 0, 1'b1, 255, -1, -1);
      runFrame(20, 0, 0, 0, 0);
      runFrame(256, 64, 2, 0, 0);
      runFrame(256, 64, 1, 64, 0);

      applyStimulus(256, 64, 1, 64, 0, 1'b0, 0, -1, 200);
      runFrame(256, 64, 2, 0, 0);
      runFrame(256, 64, 1, 64, 0);

      repeat (40) runFrame(250 + int'($urandom_range(0, 12)), int'($urandom_range(D_LO, D_HI)), 0, 0, 0);

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
